// File: rtl/wb_sched.sv
// Writeback scheduler: arbitrates the EXU and LSU results onto the single register-file
// write port and keeps a per-register pending scoreboard that blocks RAW/WAW issue hazards.
module wb_sched #(
  parameter  int XLEN = 64,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_rd_we,
  output logic            iss_ready,
  input  logic            exu_valid,
  input  logic [AW-1:0]   exu_rd,
  input  logic [XLEN-1:0] exu_data,
  output logic            exu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy_vec
);

  typedef enum logic {SRC_EXU = 1'b0, SRC_LSU = 1'b1} src_e;

  src_e            r_last_grant;
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_gnt_exu;
  logic            w_gnt_lsu;
  logic            w_acc;
  logic            w_acc_wr;
  logic            w_issue_set;
  logic [AW-1:0]   w_acc_rd;
  logic [XLEN-1:0] w_acc_data;

  assign iss_ready = !(r_pending[iss_rs1] && (iss_rs1 != '0)) &&
                     !(r_pending[iss_rs2] && (iss_rs2 != '0)) &&
                     !(iss_rd_we && r_pending[iss_rd] && (iss_rd != '0));

  assign w_issue_set = iss_valid && iss_ready && iss_rd_we && (iss_rd != '0);

  // Round-robin on contention: the source that did not win last time goes first.
  assign w_gnt_exu = exu_valid && (!lsu_valid || (r_last_grant == SRC_LSU));
  assign w_gnt_lsu = lsu_valid && !w_gnt_exu;
  assign exu_ready = w_gnt_exu;
  assign lsu_ready = w_gnt_lsu;

  assign w_acc      = w_gnt_exu || w_gnt_lsu;
  assign w_acc_rd   = w_gnt_exu ? exu_rd   : lsu_rd;
  assign w_acc_data = w_gnt_exu ? exu_data : lsu_data;
  assign w_acc_wr   = w_acc && (w_acc_rd != '0);

  // Clear is applied first so that a same-index set overrides it.
  always_comb begin
    w_pending_nxt = r_pending;
    if (rf_we) w_pending_nxt[rf_waddr] = 1'b0;
    if (w_issue_set) w_pending_nxt[iss_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_last_grant <= SRC_LSU;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      rf_we     <= w_acc_wr;
      if (w_acc_wr) begin
        rf_waddr <= w_acc_rd;
        rf_wdata <= w_acc_data;
      end
      if (w_acc) r_last_grant <= w_gnt_exu ? SRC_EXU : SRC_LSU;
    end
  end

  assign busy_vec = r_pending;

endmodule

// File: tb/tb_wb_sched.sv
// Scoreboard bench for wb_sched: expected writes are queued when a grant is seen
// and matched against the register-file write port one cycle later.
module tb_wb_sched;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  logic            clk;
  logic            rst_n;
  logic            iss_valid;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic [4:0]      iss_rd;
  logic            iss_rd_we;
  logic            iss_ready;
  logic            exu_valid;
  logic [4:0]      exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            exu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] busy_vec;

  int n_chk  = 0;
  int n_fail = 0;
  logic [68:0] sb_q[$];

  wb_sched #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_rd_we(iss_rd_we), .iss_ready(iss_ready),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Write-port monitor: every rf write must match the oldest queued acceptance.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (sb_q.size() == 0) begin
        chk("unexp_wr", 64'(rf_we), 64'd0);
      end else begin
        logic [68:0] e;
        e = sb_q.pop_front();
        chk("wr_addr", 64'(rf_waddr), 64'(e[68:64]));
        chk("wr_data", rf_wdata, e[63:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_exu_win;
    rst_n = 1'b0;
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_rd_we = 0;
    exu_valid = 0; exu_rd = 0; exu_data = '0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = '0;

    at_neg();
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // Contention straight out of reset: EXU must win first, then alternate.
    exu_valid = 1; exu_rd = 5'd1; exu_data = 64'hE000_0000_0000_0001;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 64'hC000_0000_0000_0001;
    exp_exu_win = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("cont_exu_rdy", 64'(exu_ready), 64'(exp_exu_win));
      chk("cont_lsu_rdy", 64'(lsu_ready), 64'(!exp_exu_win));
      if (exp_exu_win) sb_q.push_back({exu_rd, exu_data});
      else             sb_q.push_back({lsu_rd, lsu_data});
      step();
      if (exp_exu_win) exu_data = exu_data + 64'h10;
      else             lsu_data = lsu_data + 64'h10;
      exp_exu_win = !exp_exu_win;
    end
    exu_valid = 0; lsu_valid = 0;

    // RAW on x5, cleared by an LSU load.
    iss_valid = 1; iss_rd = 5'd5; iss_rd_we = 1; iss_rs1 = 0; iss_rs2 = 0;
    at_neg();
    chk("raw_first_rdy", 64'(iss_ready), 64'd1);
    step();
    iss_rd = 0; iss_rd_we = 0; iss_rs1 = 5'd5;
    at_neg();
    chk("raw_busy5", 64'(busy_vec[5]), 64'd1);
    chk("raw_stall", 64'(iss_ready), 64'd0);
    iss_valid = 0;
    lsu_valid = 1; lsu_rd = 5'd5; lsu_data = 64'hDEAD_BEEF;
    #1;
    chk("raw_stall_novld", 64'(iss_ready), 64'd0);
    chk("raw_lsu_rdy", 64'(lsu_ready), 64'd1);
    sb_q.push_back({lsu_rd, lsu_data});
    step();
    lsu_valid = 0;
    at_neg();
    chk("raw_we_n1", 64'(rf_we), 64'd1);
    chk("raw_still_stall", 64'(iss_ready), 64'd0);
    step();
    at_neg();
    chk("raw_rdy_n2", 64'(iss_ready), 64'd1);
    chk("raw_busy5_clr", 64'(busy_vec[5]), 64'd0);
    iss_rs1 = 0;

    // WAW on x7.
    iss_valid = 1; iss_rd = 5'd7; iss_rd_we = 1;
    step();
    at_neg();
    chk("waw_stall", 64'(iss_ready), 64'd0);
    exu_valid = 1; exu_rd = 5'd7; exu_data = 64'h7777_0000_1234_5678;
    #1;
    chk("waw_exu_rdy", 64'(exu_ready), 64'd1);
    sb_q.push_back({exu_rd, exu_data});
    step();
    exu_valid = 0;
    at_neg();
    chk("waw_stall_n1", 64'(iss_ready), 64'd0);
    step();
    at_neg();
    chk("waw_rdy_n2", 64'(iss_ready), 64'd1);
    iss_valid = 0; iss_rd_we = 0; iss_rd = 0;

    // x0 as destination, as result target and as source.
    step();
    iss_valid = 1; iss_rd = 0; iss_rd_we = 1; iss_rs1 = 0; iss_rs2 = 0;
    at_neg();
    chk("x0_iss_rdy", 64'(iss_ready), 64'd1);
    step();
    iss_valid = 0; iss_rd_we = 0;
    at_neg();
    chk("x0_busy", 64'(busy_vec), 64'd0);
    exu_valid = 1; exu_rd = 0; exu_data = 64'h0BAD;
    #1;
    chk("x0_exu_rdy", 64'(exu_ready), 64'd1);
    step();
    exu_valid = 0;
    at_neg();
    chk("x0_no_we", 64'(rf_we), 64'd0);

    // Back-to-back EXU results to x3 and x4.
    step();
    iss_valid = 1; iss_rd = 5'd3; iss_rd_we = 1;
    step();
    iss_rd = 5'd4;
    step();
    iss_valid = 0; iss_rd_we = 0; iss_rd = 0;
    exu_valid = 1; exu_rd = 5'd3; exu_data = 64'h3333;
    at_neg();
    chk("b2b_busy34", 64'(busy_vec[4:3]), 64'd3);
    chk("b2b_rdy3", 64'(exu_ready), 64'd1);
    sb_q.push_back({exu_rd, exu_data});
    step();
    exu_rd = 5'd4; exu_data = 64'h4444;
    at_neg();
    chk("b2b_rdy4", 64'(exu_ready), 64'd1);
    sb_q.push_back({exu_rd, exu_data});
    chk("b2b_we_a", 64'(rf_we), 64'd1);
    chk("b2b_busy_a", 64'(busy_vec[4:3]), 64'd3);
    step();
    exu_valid = 0;
    at_neg();
    chk("b2b_we_b", 64'(rf_we), 64'd1);
    chk("b2b_busy_b", 64'(busy_vec[4:3]), 64'd2);
    step();
    at_neg();
    chk("b2b_we_end", 64'(rf_we), 64'd0);
    chk("b2b_busy_end", 64'(busy_vec[4:3]), 64'd0);

    // Reset mid-stream with an EXU result on offer.
    step();
    iss_valid = 1; iss_rd = 5'd9; iss_rd_we = 1;
    step();
    iss_valid = 0; iss_rd_we = 0; iss_rd = 0;
    exu_valid = 1; exu_rd = 5'd9; exu_data = 64'h9999_9999;
    at_neg();
    chk("mid_busy9", 64'(busy_vec[9]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_busy", 64'(busy_vec), 64'd0);
    exu_valid = 0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("post_rst_no_we", 64'(rf_we), 64'd0);
    end

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_sched.md
Name: wb_sched

Overview:
- Writeback scheduler and scoreboard in front of the 32x64 integer register file (one synchronous write port, x0 hard-wired to zero).
- Shares the single write port between two producers: the EXU (single-cycle ALU results) and the LSU (multi-cycle load results).
- Tracks a pending bit per architectural register and stalls issue on RAW/WAW hazards.
- Sits between the IDU issue stage and the register file write port.

Parameters:
- XLEN, 64, data width of results and of the register-file write data.
- NREG, 32, number of architectural registers; address width is log2(NREG)=5.

Ports:
- clk  input  1  system clock, all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- iss_valid  input  1  IDU presents an instruction for issue
- iss_rs1  input  5  source register 1
- iss_rs2  input  5  source register 2
- iss_rd  input  5  destination register
- iss_rd_we  input  1  instruction writes rd
- iss_ready  output  1  issue allowed this cycle (no hazard)
- exu_valid  input  1  EXU result valid
- exu_rd  input  5  EXU destination
- exu_data  input  XLEN  EXU result
- exu_ready  output  1  EXU result accepted this cycle
- lsu_valid  input  1  LSU load result valid
- lsu_rd  input  5  LSU destination
- lsu_data  input  XLEN  LSU result
- lsu_ready  output  1  LSU result accepted this cycle
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  register-file write address
- rf_wdata  output  XLEN  register-file write data
- busy_vec  output  NREG  current pending bits, for debug and trace

Behaviour:
- Reset, asynchronous on rst_n low:
  - pending[31:0]=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Round-robin pointer last_grant=LSU, so the EXU wins the first tie.
  - Any result held by a producer at the time of reset is discarded and never reaches the register file.
- Hazard check (combinational):
  - iss_ready = !(pending[iss_rs1] & iss_rs1!=0) & !(pending[iss_rs2] & iss_rs2!=0) & !(iss_rd_we & pending[iss_rd] & iss_rd!=0).
  - iss_ready is independent of iss_valid.
  - An issue fires when iss_valid & iss_ready.
- Scoreboard set: at the edge where an issue fires with iss_rd_we & iss_rd!=0, pending[iss_rd] is set to 1.
- Arbitration (combinational grant, one winner per cycle):
  - Only one valid: that source is granted, and its ready=1.
  - Both valid: the source not equal to last_grant is granted, and the loser's ready=0.
  - last_grant updates at the edge of a successful transfer (valid & ready).
  - A producer holds valid, rd and data stable until ready. The scheduler never drops an accepted result.
- Write-port register (latency 1):
  - A result accepted at edge N drives rf_we=1 with rf_waddr/rf_wdata during cycle N+1.
  - The register file captures it at edge N+1.
  - Without an accepted result, rf_we=0 in the next cycle; rf_waddr and rf_wdata hold their last value.
  - A result with rd==0 is accepted (ready=1) but rf_we stays 0 and pending is unchanged.
- Scoreboard clear: pending[rf_waddr] is cleared at the edge where rf_we=1 (edge N+1). Issue of a dependent instruction is therefore allowed from cycle N+2, when the register file already holds the value.
- Simultaneous set and clear of the same index: the set wins. This cannot occur when iss_ready is honoured, but the rule is fixed.
- Result to a register whose pending bit is 0: written normally, pending stays 0. No error is flagged.
- busy_vec = pending, registered. Bit 0 is always 0.

Test Plan:
- Reset: assert rst_n=0 mid-stream with exu_valid=1 -> rf_we=0, busy_vec=0, and no write of that result after release.
- RAW stall:
  - Stimulus: issue rd=x5 (iss_rd_we=1), then offer rs1=x5.
  - Required: busy_vec[5]=1 and iss_ready=0.
  - Stimulus: lsu_valid with rd=5, data=64'hDEAD_BEEF accepted at edge N.
  - Required: rf_we=1, rf_waddr=5, rf_wdata=64'hDEAD_BEEF in N+1; iss_ready=1 in N+2.
- WAW stall: x7 pending, issue with iss_rd=7, iss_rd_we=1, rs1=rs2=0 -> iss_ready=0 until the x7 write commits.
- Contention:
  - Stimulus: exu_valid and lsu_valid held high for 4 cycles (rd 1/2, distinct data) directly after reset.
  - Required: grants alternate EXU, LSU, EXU, LSU; the loser's ready=0 each cycle; all 4 writes appear on rf_* in that order.
- x0 handling:
  - Issue with iss_rd=0 -> busy_vec unchanged.
  - exu_valid with rd=0 -> exu_ready=1 and rf_we stays 0.
  - Source operand x0 never stalls.
- Back-to-back: EXU results to x3 then x4 on consecutive cycles with no LSU traffic -> rf_we high for 2 consecutive cycles, and pending bits 3 and 4 clear at the matching edges.
